bolme_kontrol: RTL and testbench
================================

# bolme_kontrol

- Sequential fixed-point divider controller.
- Accepts an 8.2 fixed-point dividend and a 6-bit integer divisor under a start/done handshake.
- Computes the quotient truncated to hundredths through a multi-cycle restoring-division datapath, then converts it to five BCD digits with a multi-cycle double-dabble.
- Replaces the single-cycle combinational divider in the lab datapath where area and timing matter.

## Interface
Parameters:
- None. Widths are fixed: 10-bit dividend (8.2), 6-bit divisor, 15-bit scaled quotient, 5 BCD digits.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- baslat  in  1  start request, sampled only in BOSTA.
- bolunen  in  10  dividend, value = bolunen/4.
- bolen  in  6  divisor, unsigned integer.
- mesgul  out  1  high whenever state is not BOSTA.
- bitti  out  1  one-cycle completion pulse.
- hata  out  1  divide-by-zero flag for the last operation.
- yuzler, onlar, birler  out  4 each  integer BCD digits (hundreds, tens, ones).
- ondalik1, ondalik2  out  4 each  fractional BCD digits (tenths, hundredths).

## Operation
- Result definition: Q = floor(bolunen*25 / bolen), range 0..25575. Digits are the BCD of Q: yuzler.onlar birler . ondalik1 ondalik2. Example: 625/3 → 208 → 0,0,2,0,8.
- FSM states, in order: BOSTA, CARP, BOL, BCD, BITTI.
- BOSTA: on baslat=1, latch bolunen and bolen into internal registers.
  - If bolen==0: go to BITTI with hata=1 and all digits 0.
  - Otherwise: clear hata and go to CARP.
- CARP (1 cycle): N = (D<<4)+(D<<3)+D, 15 bits, no overflow possible. Go to BOL.
- BOL (15 cycles, restoring division, MSB first):
  - r = {r[5:0], N[14]}, with r 7 bits wide.
  - If r ≥ bolen: subtract bolen from r and shift in quotient bit 1; else shift in 0.
  - A 4-bit step counter runs 0..14. Go to BCD after the 15th step.
- BCD (15 cycles, double-dabble on a 20-bit BCD register):
  - Before each shift, add 3 to every nibble ≥ 5.
  - Go to BITTI after the 15th shift.
- BITTI (1 cycle): bitti=1. Return to BOSTA.
  - Digit outputs are registered on the edge that enters BITTI and hold until the next entry into BITTI.
- baslat is ignored in every state except BOSTA. Operand changes after the sampling edge have no effect.
- The remainder is discarded.

## Timing
- Let t be the edge that samples baslat=1 in BOSTA.
- Normal path:
  - CARP at t.
  - BOL edges t+1..t+16.
  - BCD edges t+17..t+31 (BITTI entered at t+31).
  - bitti high in the cycle after edge t+31; BOSTA at t+32.
  - Total latency: 31 edges.
- Divide by zero: BITTI entered at t; bitti high in the cycle after t; BOSTA at t+1.
- mesgul is high from edge t until the edge returning to BOSTA, BITTI cycle included.
- Back-to-back: with baslat held high, the next operation is sampled on the first BOSTA cycle, i.e. the edge after BITTI. Minimum issue interval is 32 cycles.
- Reset is asynchronous and takes effect mid-operation:
  - State → BOSTA.
  - mesgul, bitti, hata = 0.
  - All digits = 0.
  - Step counter and datapath registers = 0.
  - No stale bitti after release.

## Structure
- Shared package bolme_pkg holds:
  - state encoding (BOSTA, CARP, BOL, BCD, BITTI);
  - BOL_ADIM=15, BCD_ADIM=15, CARPAN=25;
  - width constants for dividend, divisor, quotient and BCD.
- One combinational sub-module, bcd_duzelt: 20-bit BCD in → add-3-corrected 20-bit out. It performs one double-dabble correction step and is instantiated once in the BCD state path.
- FSM, step counter, division datapath and output registers stay in bolme_kontrol.

## Test plan
- bolunen=25 (6.25), bolen=3 → bitti 31 edges after start; digits 0,0,2,0,8; hata=0.
- bolunen=82 (20.50), bolen=2 → 0,1,0,2,5. Then bolunen=240, bolen=4 → 0,1,5,0,0.
- bolunen=1023, bolen=1 → 2,5,5,7,5 (maximum). Also bolunen=1, bolen=63 → 0,0,0,0,0.
- bolen=0 → bitti one edge after start; hata=1; digits 0; the next valid start clears hata.
- baslat pulsed during BOL, and operands changed after t → result unchanged; baslat held high → second result exactly 32 cycles after the first bitti.
- rst_n low at edge t+10 → all outputs 0 immediately, asynchronously. After release, a new start completes with correct digits and no spurious bitti.

Source files
------------

// File: rtl/bolme_pkg.sv
// Shared types and constants for the bolme_kontrol sequential fixed-point divider.
package bolme_pkg;

  typedef enum logic [2:0] {BOSTA, CARP, BOL, BCD, BITTI} durum_t;

  localparam int BOL_ADIM  = 15;
  localparam int BCD_ADIM  = 15;
  localparam int CARPAN    = 25;

  localparam int BOLUNEN_W = 10;
  localparam int BOLEN_W   = 6;
  localparam int BOLUM_W   = 15;
  localparam int BCD_W     = 20;
  localparam int SAYAC_W   = 4;

  localparam logic [SAYAC_W-1:0] BOL_SON = SAYAC_W'(BOL_ADIM - 1);
  localparam logic [SAYAC_W-1:0] BCD_SON = SAYAC_W'(BCD_ADIM - 1);

  // 25 = 16 + 8 + 1, so this reduces to two shifted adds; 1023*25 still fits in 15 bits.
  function automatic logic [BOLUM_W-1:0] olcekle(input logic [BOLUNEN_W-1:0] d);
    return BOLUM_W'(d) * BOLUM_W'(CARPAN);
  endfunction

endpackage

// File: rtl/bcd_duzelt.sv
// One double-dabble correction step: add 3 to every BCD nibble that is 5 or more.
module bcd_duzelt
  import bolme_pkg::*;
(
  input  logic [BCD_W-1:0] ham,
  output logic [BCD_W-1:0] duzeltilmis
);

  always_comb begin
    // NOTE: the full-vector default before the loop keeps every bit assigned on all paths, so no latch is inferred.
    duzeltilmis = ham;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (ham[4*i +: 4] >= 4'd5)
        duzeltilmis[4*i +: 4] = ham[4*i +: 4] + 4'd3;
    end
  end

endmodule

// File: rtl/bolme_kontrol.sv
// Sequential divider: Q = floor(bolunen*25/bolen) by restoring division, then BCD by double-dabble.
module bolme_kontrol
  import bolme_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baslat,
  input  logic [BOLUNEN_W-1:0] bolunen,
  input  logic [BOLEN_W-1:0]   bolen,
  output logic                 mesgul,
  output logic                 bitti,
  output logic                 hata,
  output logic [3:0]           yuzler,
  output logic [3:0]           onlar,
  output logic [3:0]           birler,
  output logic [3:0]           ondalik1,
  output logic [3:0]           ondalik2
);

  durum_t               durum;
  logic [BOLUNEN_W-1:0] bolunen_r;
  logic [BOLEN_W-1:0]   bolen_r;
  logic [BOLUM_W-1:0]   kay;      // scaled dividend, shifted out MSB-first; quotient shifts in behind it
  logic [BOLEN_W-1:0]   kalan;
  logic [SAYAC_W-1:0]   sayac;
  logic [BCD_W-1:0]     bcd;
  logic [BCD_W-1:0]     sonuc;

  logic [BOLEN_W:0]     kalan_kaydir;
  logic                 q_bit;
  logic [BOLEN_W-1:0]   fark;
  logic [BCD_W-1:0]     duz;
  logic [BCD_W-1:0]     bcd_kaydir;

  // Remainder stays below bolen (<= 63), so after the shift it fits 7 bits and the difference fits 6.
  assign kalan_kaydir = {kalan, kay[BOLUM_W-1]};
  assign q_bit        = (kalan_kaydir >= {1'b0, bolen_r});
  assign fark         = kalan_kaydir[BOLEN_W-1:0] - bolen_r;

  bcd_duzelt u_bcd_duzelt (
    .ham         (bcd),
    .duzeltilmis (duz)
  );

  assign bcd_kaydir = BCD_W'({duz, kay[BOLUM_W-1]});

  assign mesgul   = (durum != BOSTA);
  assign yuzler   = sonuc[19:16];
  assign onlar    = sonuc[15:12];
  assign birler   = sonuc[11:8];
  assign ondalik1 = sonuc[7:4];
  assign ondalik2 = sonuc[3:0];

  // NOTE: datapath registers are reset too, so an aborted operation leaves nothing behind after rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum     <= BOSTA;
      bolunen_r <= '0;
      bolen_r   <= '0;
      kay       <= '0;
      kalan     <= '0;
      sayac     <= '0;
      bcd       <= '0;
      sonuc     <= '0;
      bitti     <= 1'b0;
      hata      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register in this block sees the pre-edge values.
      bitti <= 1'b0;
      case (durum)
        // BITTI's exit edge doubles as the first BOSTA sampling edge, giving a 32-cycle issue interval.
        BOSTA, BITTI: begin
          durum <= BOSTA;
          if (baslat) begin
            bolunen_r <= bolunen;
            bolen_r   <= bolen;
            if (bolen == '0) begin
              hata  <= 1'b1;
              sonuc <= '0;
              bitti <= 1'b1;
              durum <= BITTI;
            end else begin
              hata  <= 1'b0;
              durum <= CARP;
            end
          end
        end
        CARP: begin
          kay   <= olcekle(bolunen_r);
          kalan <= '0;
          sayac <= '0;
          durum <= BOL;
        end
        BOL: begin
          kalan <= q_bit ? fark : kalan_kaydir[BOLEN_W-1:0];
          kay   <= {kay[BOLUM_W-2:0], q_bit};
          if (sayac == BOL_SON) begin
            sayac <= '0;
            bcd   <= '0;
            durum <= BCD;
          end else begin
            sayac <= sayac + 4'd1;
          end
        end
        BCD: begin
          bcd <= bcd_kaydir;
          kay <= {kay[BOLUM_W-2:0], 1'b0};
          if (sayac == BCD_SON) begin
            sayac <= '0;
            sonuc <= bcd_kaydir;
            bitti <= 1'b1;
            durum <= BITTI;
          end else begin
            sayac <= sayac + 4'd1;
          end
        end
        default: durum <= BOSTA;
      endcase
    end
  end

endmodule

// File: tb/tb_bolme_kontrol.sv
// Directed self-checking bench for bolme_kontrol with hand-computed BCD results.
module tb_bolme_kontrol;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baslat = 1'b0;
  logic [9:0] bolunen = '0;
  logic [5:0] bolen = '0;
  logic       mesgul, bitti, hata;
  logic [3:0] yuzler, onlar, birler, ondalik1, ondalik2;
  logic [19:0] rakamlar;

  int n_kontrol = 0;
  int n_hata    = 0;

  bolme_kontrol dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .baslat   (baslat),
    .bolunen  (bolunen),
    .bolen    (bolen),
    .mesgul   (mesgul),
    .bitti    (bitti),
    .hata     (hata),
    .yuzler   (yuzler),
    .onlar    (onlar),
    .birler   (birler),
    .ondalik1 (ondalik1),
    .ondalik2 (ondalik2)
  );

  assign rakamlar = {yuzler, onlar, birler, ondalik1, ondalik2};

  always #5 clk = ~clk;

  task automatic check(input string etiket, input int gozlenen, input int beklenen);
    n_kontrol++;
    if (gozlenen !== beklenen) begin
      n_hata++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", etiket, gozlenen, beklenen);
    end
  endtask

  // Bounded wait (sampled #1 after each edge) until bitti is high; returns edges after t.
  task automatic bitti_bekle(input string etiket, output int gecikme);
    gecikme = 0;
    while (!bitti && gecikme < 80) begin
      @(posedge clk); #1;
      gecikme++;
    end
    if (!bitti) check({etiket, "_zaman_asimi"}, 0, 1);
  endtask

  // Presents operands with baslat for one sampling edge t, then waits for bitti.
  task automatic calistir(input string etiket, input logic [9:0] a, input logic [5:0] b,
                          output int gecikme);
    @(negedge clk);
    bolunen = a; bolen = b; baslat = 1'b1;
    @(posedge clk); #1;
    baslat = 1'b0;
    check({etiket, "_mesgul"}, int'(mesgul), 1);
    bitti_bekle(etiket, gecikme);
  endtask

  initial begin
    int g;
    int bitti_say;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_mesgul", int'(mesgul), 0);
    check("reset_bitti", int'(bitti), 0);
    check("reset_hata", int'(hata), 0);
    check("reset_rakam", int'(rakamlar), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 6.25 / 3 = 2.0833 -> 208
    calistir("v25_3", 10'd25, 6'd3, g);
    check("v25_3_gecikme", g, 31);
    check("v25_3_rakam", int'(rakamlar), 'h00208);
    check("v25_3_hata", int'(hata), 0);
    @(posedge clk); #1;
    check("v25_3_bitti_tek", int'(bitti), 0);
    check("v25_3_bosta", int'(mesgul), 0);

    // 20.50 / 2 = 10.25, then 60.00 / 4 = 15.00
    calistir("v82_2", 10'd82, 6'd2, g);
    check("v82_2_rakam", int'(rakamlar), 'h01025);
    calistir("v240_4", 10'd240, 6'd4, g);
    check("v240_4_rakam", int'(rakamlar), 'h01500);

    // Maximum 255.75 / 1, then 0.25 / 63 truncates to 0
    calistir("v1023_1", 10'd1023, 6'd1, g);
    check("v1023_1_rakam", int'(rakamlar), 'h25575);
    calistir("v1_63", 10'd1, 6'd63, g);
    check("v1_63_rakam", int'(rakamlar), 'h00000);

    // Divide by zero after a non-zero result, then a valid start clears hata
    calistir("v25_3b", 10'd25, 6'd3, g);
    calistir("sifir", 10'd500, 6'd0, g);
    check("sifir_gecikme", g, 0);
    check("sifir_hata", int'(hata), 1);
    check("sifir_rakam", int'(rakamlar), 0);
    @(posedge clk); #1;
    check("sifir_bosta", int'(mesgul), 0);
    calistir("sifir_sonra", 10'd82, 6'd2, g);
    check("sifir_sonra_hata", int'(hata), 0);
    check("sifir_sonra_rakam", int'(rakamlar), 'h01025);

    // baslat pulsed in BOL and operands changed after t: result is 240/4
    @(negedge clk);
    bolunen = 10'd240; bolen = 6'd4; baslat = 1'b1;
    @(posedge clk); #1;
    baslat = 1'b0; bolunen = 10'd1023; bolen = 6'd1;
    repeat (5) @(posedge clk);
    #1 baslat = 1'b1;
    @(posedge clk); #1;
    baslat = 1'b0;
    g = 6;
    begin
      int ek;
      bitti_bekle("yoksay", ek);
      g += ek;
    end
    check("yoksay_gecikme", g, 31);
    check("yoksay_rakam", int'(rakamlar), 'h01500);

    // baslat held high: second bitti exactly 32 cycles after the first
    @(negedge clk);
    bolunen = 10'd82; bolen = 6'd2; baslat = 1'b1;
    @(posedge clk); #1;
    bitti_bekle("ardisik1", g);
    check("ardisik1_gecikme", g, 31);
    check("ardisik1_rakam", int'(rakamlar), 'h01025);
    bolunen = 10'd25; bolen = 6'd3;
    g = 0;
    do begin
      @(posedge clk); #1;
      g++;
    end while (!bitti && g < 80);
    baslat = 1'b0;
    check("ardisik_aralik", g, 32);
    check("ardisik2_rakam", int'(rakamlar), 'h00208);
    @(posedge clk); #1;
    check("ardisik_bosta", int'(mesgul), 0);

    // Asynchronous reset in the middle of an operation
    calistir("once", 10'd1023, 6'd1, g);
    @(negedge clk);
    bolunen = 10'd82; bolen = 6'd0; baslat = 1'b1;
    @(posedge clk); #1;
    baslat = 1'b0;
    check("once_hata", int'(hata), 1);
    @(negedge clk);
    bolunen = 10'd82; bolen = 6'd2; baslat = 1'b1;
    @(posedge clk); #1;
    baslat = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mesgul", int'(mesgul), 0);
    check("rst_bitti", int'(bitti), 0);
    check("rst_hata", int'(hata), 0);
    check("rst_rakam", int'(rakamlar), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bitti_say = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bitti || mesgul) bitti_say++;
    end
    check("rst_sonra_sessiz", bitti_say, 0);
    calistir("rst_sonra", 10'd1023, 6'd63, g);
    check("rst_sonra_gecikme", g, 31);
    check("rst_sonra_rakam", int'(rakamlar), 'h00405);
    check("rst_sonra_hata", int'(hata), 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_kontrol, n_hata);
    $finish;
  end

endmodule
